// File: rtl/pe_net_if.sv
// rtl/pe_net_if.sv - PE-side network interface: TX/RX packet FIFOs between a PE and its router tile
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   tx_valid/tx_ready/tx_x/tx_y/tx_data  PE -> TX FIFO packet push
//   i_v/i_x/i_y/i_d/i_ack          TX FIFO head -> router injection port
//   o_v/o_d/client_b               router ejection -> RX FIFO, with backpressure
//   rx_valid/rx_ready/rx_data      RX FIFO head -> PE
//   tx_count/rx_count              FIFO occupancies
//   head_stall                     saturating cycles the TX head has waited unacked
module pe_net_if #(
    parameter int X_W       = 2,
    parameter int Y_W       = 2,
    parameter int D_W       = 32,
    parameter int TXQ_DEPTH = 4,
    parameter int RXQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic [X_W-1:0]               tx_x,
    input  logic [Y_W-1:0]               tx_y,
    input  logic [D_W-1:0]               tx_data,
    output logic                         i_v,
    output logic [X_W-1:0]               i_x,
    output logic [Y_W-1:0]               i_y,
    output logic [D_W-1:0]               i_d,
    input  logic                         i_ack,
    input  logic                         o_v,
    input  logic [D_W-1:0]               o_d,
    output logic                         client_b,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [D_W-1:0]               rx_data,
    output logic [$clog2(TXQ_DEPTH):0]   tx_count,
    output logic [$clog2(RXQ_DEPTH):0]   rx_count,
    output logic [7:0]                   head_stall
);

    localparam int TPW = $clog2(TXQ_DEPTH);
    localparam int RPW = $clog2(RXQ_DEPTH);
    localparam int TCW = TPW + 1;
    localparam int RCW = RPW + 1;
    localparam int PKW = X_W + Y_W + D_W;

    localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TXQ_DEPTH);
    localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RXQ_DEPTH);

    // ---------------- TX FIFO ----------------
    logic [PKW-1:0] tx_mem [TXQ_DEPTH];
    logic [TPW-1:0] tx_wr;
    logic [TPW-1:0] tx_rd;
    logic [TCW-1:0] tx_cnt;
    logic           tx_push;
    logic           tx_pop;

    // Status comes only from the registered count so nothing here is
    // combinationally dependent on an input.
    assign tx_ready = (tx_cnt != TX_FULL_CNT);
    assign i_v      = (tx_cnt != '0);
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = i_ack && i_v;   // ack with no request is ignored

    assign {i_x, i_y, i_d} = tx_mem[tx_rd];
    assign tx_count        = tx_cnt;

    // Payload storage needs no reset; it is only observed while i_v=1.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr] <= {tx_x, tx_y, tx_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) begin
                tx_wr <= tx_wr + TPW'(1);
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + TPW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + TCW'(1);
                2'b01:   tx_cnt <= tx_cnt - TCW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [D_W-1:0] rx_mem [RXQ_DEPTH];
    logic [RPW-1:0] rx_wr;
    logic [RPW-1:0] rx_rd;
    logic [RCW-1:0] rx_cnt;
    logic           rx_push;
    logic           rx_pop;

    // client_b deliberately ignores rx_ready: a full FIFO being popped still
    // refuses the push that cycle, breaking any loop through the router.
    assign client_b = (rx_cnt == RX_FULL_CNT);
    assign rx_valid = (rx_cnt != '0);
    assign rx_push  = o_v && !client_b;
    assign rx_pop   = rx_valid && rx_ready;

    assign rx_data  = rx_mem[rx_rd];
    assign rx_count = rx_cnt;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr] <= o_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) begin
                rx_wr <= rx_wr + RPW'(1);
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + RPW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + RCW'(1);
                2'b01:   rx_cnt <= rx_cnt - RCW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ---------------- Injection starvation ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_stall <= '0;
        end else if (i_v && !i_ack) begin
            if (head_stall != 8'hFF) begin
                head_stall <= head_stall + 8'd1;
            end
        end else begin
            head_stall <= '0;
        end
    end

endmodule

// File: tb/tb_pe_net_if.sv
// tb/tb_pe_net_if.sv - scoreboard testbench for pe_net_if
module tb_pe_net_if;

    localparam int X_W = 2;
    localparam int Y_W = 2;
    localparam int D_W = 32;
    localparam int PKW = X_W + Y_W + D_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            tx_valid;
    logic            tx_ready;
    logic [X_W-1:0]  tx_x;
    logic [Y_W-1:0]  tx_y;
    logic [D_W-1:0]  tx_data;
    logic            i_v;
    logic [X_W-1:0]  i_x;
    logic [Y_W-1:0]  i_y;
    logic [D_W-1:0]  i_d;
    logic            i_ack;
    logic            o_v;
    logic [D_W-1:0]  o_d;
    logic            client_b;
    logic            rx_valid;
    logic            rx_ready;
    logic [D_W-1:0]  rx_data;
    logic [2:0]      tx_count;
    logic [2:0]      rx_count;
    logic [7:0]      head_stall;

    pe_net_if #(.X_W(X_W), .Y_W(Y_W), .D_W(D_W), .TXQ_DEPTH(4), .RXQ_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_x(tx_x), .tx_y(tx_y), .tx_data(tx_data),
        .i_v(i_v), .i_x(i_x), .i_y(i_y), .i_d(i_d), .i_ack(i_ack),
        .o_v(o_v), .o_d(o_d), .client_b(client_b),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_count(tx_count), .rx_count(rx_count), .head_stall(head_stall)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [PKW-1:0] txq[$];
    logic [D_W-1:0] rxq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic [D_W-1:0] d);
        tx_valid = 1'b1;
        tx_x     = x;
        tx_y     = y;
        tx_data  = d;
        txq.push_back({x, y, d});
    endtask

    task automatic push_rx(input logic [D_W-1:0] d);
        o_v = 1'b1;
        o_d = d;
        rxq.push_back(d);
    endtask

    // Monitor: every transfer the DUT presents is compared with the scoreboard head.
    logic [PKW-1:0] exp_tx;
    logic [D_W-1:0] exp_rx;
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_v && i_ack) begin
                if (txq.size() == 0) begin
                    total++;
                    $display("FAIL tx_unexpected actual=%0h required=no packet", {i_x, i_y, i_d});
                end else begin
                    exp_tx = txq.pop_front();
                    check("tx_packet", 64'({i_x, i_y, i_d}), 64'(exp_tx));
                end
            end
            if (rx_valid && rx_ready) begin
                if (rxq.size() == 0) begin
                    total++;
                    $display("FAIL rx_unexpected actual=%0h required=no packet", rx_data);
                end else begin
                    exp_rx = rxq.pop_front();
                    check("rx_packet", 64'(rx_data), 64'(exp_rx));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int bad;
    logic [PKW-1:0] head;

    initial begin
        rst_n = 1'b0; tx_valid = 1'b0; tx_x = '0; tx_y = '0; tx_data = '0;
        i_ack = 1'b0; o_v = 1'b0; o_d = '0; rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_v", 64'(i_v), 64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_client_b", 64'(client_b), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        check("rst_tx_count", 64'(tx_count), 64'd0);
        check("rst_rx_count", 64'(rx_count), 64'd0);
        check("rst_head_stall", 64'(head_stall), 64'd0);
        to_edge();
        rst_n = 1'b1;

        // Spurious ack with an empty TX FIFO
        i_ack = 1'b1;
        repeat (3) to_edge();
        @(negedge clk);
        check("spur_tx_count", 64'(tx_count), 64'd0);
        check("spur_i_v", 64'(i_v), 64'd0);
        check("spur_head_stall", 64'(head_stall), 64'd0);
        to_edge();

        // Single inject with ack tied high
        push_tx(2'd1, 2'd2, 32'hA5);
        @(negedge clk);
        check("t1_count_before", 64'(tx_count), 64'd0);
        to_edge();
        tx_valid = 1'b0;
        @(negedge clk);
        check("t1_i_v_on", 64'(i_v), 64'd1);
        check("t1_count_one", 64'(tx_count), 64'd1);
        to_edge();
        @(negedge clk);
        check("t1_i_v_off", 64'(i_v), 64'd0);
        check("t1_count_zero", 64'(tx_count), 64'd0);
        to_edge();

        // Fill TX and starve it
        i_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_tx(2'(k), 2'(3 - k), 32'h100 + 32'(k));
            to_edge();
        end
        tx_valid = 1'b0;
        @(negedge clk);
        check("t2_tx_ready_full", 64'(tx_ready), 64'd0);
        check("t2_tx_count_full", 64'(tx_count), 64'd4);
        head = {2'd0, 2'd3, 32'h100};
        bad = 0;
        to_edge();
        // Offer a packet while full; it must be refused
        tx_valid = 1'b1; tx_x = 2'd3; tx_y = 2'd3; tx_data = 32'hDEAD;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ({i_x, i_y, i_d} !== head || i_v !== 1'b1) bad++;
            to_edge();
        end
        tx_valid = 1'b0;
        @(negedge clk);
        check("t2_head_stable", 64'(bad), 64'd0);
        check("t2_stall_sat", 64'(head_stall), 64'd255);
        check("t2_count_held", 64'(tx_count), 64'd4);
        to_edge();
        i_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_drain_count", 64'(tx_count), 64'(4 - k));
            to_edge();
        end
        @(negedge clk);
        check("t2_drained", 64'(tx_count), 64'd0);
        check("t2_stall_clear", 64'(head_stall), 64'd0);
        to_edge();
        i_ack = 1'b0;

        // RX backpressure
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) push_rx(32'(k));
            else begin o_v = 1'b1; o_d = 32'(k); end
            @(negedge clk);
            check("t3_client_b", 64'(client_b), 64'(k >= 5));
            to_edge();
        end
        o_v = 1'b1; o_d = 32'd7; rx_ready = 1'b1;
        @(negedge clk);
        check("t3_b_while_pop", 64'(client_b), 64'd1);
        check("t3_count_full", 64'(rx_count), 64'd4);
        to_edge();
        o_v = 1'b0; rx_ready = 1'b0;
        @(negedge clk);
        check("t3_b_released", 64'(client_b), 64'd0);
        check("t3_count_three", 64'(rx_count), 64'd3);
        to_edge();
        rx_ready = 1'b1;
        repeat (3) to_edge();
        rx_ready = 1'b0;
        @(negedge clk);
        check("t3_rx_empty", 64'(rx_count), 64'd0);
        check("t3_rx_valid", 64'(rx_valid), 64'd0);
        to_edge();

        // Simultaneous push/pop at count 2 across pointer wrap
        bad = 0;
        for (int j = 0; j < 22; j++) begin
            push_tx(2'(j % 4), 2'((j + 1) % 4), 32'h200 + 32'(j));
            push_rx(32'h300 + 32'(j));
            i_ack    = (j >= 2);
            rx_ready = (j >= 2);
            @(negedge clk);
            if (j >= 2 && (tx_count !== 3'd2 || rx_count !== 3'd2)) bad++;
            to_edge();
        end
        tx_valid = 1'b0; o_v = 1'b0; i_ack = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        check("t4_counts_steady", 64'(bad), 64'd0);
        to_edge();
        to_edge();
        @(negedge clk);
        check("t4_tx_drained", 64'(tx_count), 64'd0);
        check("t4_rx_drained", 64'(rx_count), 64'd0);
        to_edge();
        i_ack = 1'b0; rx_ready = 1'b0;

        // Reset mid-traffic
        for (int k = 0; k < 3; k++) begin
            push_tx(2'(k), 2'(k), 32'h400 + 32'(k));
            if (k < 2) push_rx(32'h500 + 32'(k));
            else o_v = 1'b0;
            to_edge();
        end
        tx_valid = 1'b0;
        @(negedge clk);
        check("t5_tx_count", 64'(tx_count), 64'd3);
        check("t5_rx_count", 64'(rx_count), 64'd2);
        to_edge();
        rst_n = 1'b0;
        txq.delete();
        rxq.delete();
        #1;
        check("t5_i_v_async", 64'(i_v), 64'd0);
        check("t5_rx_valid_async", 64'(rx_valid), 64'd0);
        to_edge();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_i_v", 64'(i_v), 64'd0);
        check("t5_rx_valid", 64'(rx_valid), 64'd0);
        check("t5_client_b", 64'(client_b), 64'd0);
        check("t5_tx_ready", 64'(tx_ready), 64'd1);
        check("t5_tx_count_clr", 64'(tx_count), 64'd0);

        to_edge();
        check("sb_tx_leftover", 64'(txq.size()), 64'd0);
        check("sb_rx_leftover", 64'(rxq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
